// File: rtl/mips_cpu_instr_queue_if.sv
// Valid/ready word stream carrying an instruction word and its PC.
// The producer side uses the master modport, the consumer side the slave modport.
interface mips_cpu_instr_queue_if #(
  parameter int PC_WIDTH = 32
);
  logic                valid;
  logic                ready;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/mips_cpu_instr_queue.sv
// Instruction prefetch queue: buffers up to DEPTH fetched words with their PCs
// and presents the head entry pre-split into MIPS fields plus an extended
// immediate. Both sides use a valid/ready handshake; flush drops everything.
module mips_cpu_instr_queue #(
  parameter int DEPTH        = 4,
  parameter int PC_WIDTH     = 32,
  parameter int SIGN_EXT_IMM = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  mips_cpu_instr_queue_if.slave   fetch,
  mips_cpu_instr_queue_if.master  decode,
  output logic [5:0]              opcode,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [4:0]              shamt,
  output logic [5:0]              funct,
  output logic [15:0]             imm,
  output logic [31:0]             imm_ext,
  output logic [25:0]             jmp_address,
  output logic [PC_WIDTH-1:0]     out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic        in_ready_s;
  logic        out_valid_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] head_instr_s;
  logic        logical_op_s;

  // Handshake qualifiers; in_ready never looks at out_ready, and flush blocks both sides.
  always_comb begin
    in_ready_s  = (count != FULL_COUNT) && !flush;
    out_valid_s = (count != {CW{1'b0}});
    push_s      = fetch.valid && in_ready_s;
    pop_s       = out_valid_s && decode.ready && !flush;
  end

  assign fetch.ready  = in_ready_s;
  assign decode.valid = out_valid_s;

  // Pointer and occupancy state; flush empties the queue and overrides any pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_s) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem[wr_ptr] <= fetch.instr;
      pc_mem[wr_ptr]    <= fetch.pc;
    end
  end

  // Head decode; every field reads zero while the queue is empty.
  always_comb begin
    head_instr_s = instr_mem[rd_ptr];
    logical_op_s = 1'b0;
    opcode       = 6'd0;
    rs           = 5'd0;
    rt           = 5'd0;
    rd           = 5'd0;
    shamt        = 5'd0;
    funct        = 6'd0;
    imm          = 16'd0;
    imm_ext      = 32'd0;
    jmp_address  = 26'd0;
    out_pc       = {PC_WIDTH{1'b0}};
    if (out_valid_s) begin
      opcode       = head_instr_s[31:26];
      rs           = head_instr_s[25:21];
      rt           = head_instr_s[20:16];
      rd           = head_instr_s[15:11];
      shamt        = head_instr_s[10:6];
      funct        = head_instr_s[5:0];
      imm          = head_instr_s[15:0];
      jmp_address  = head_instr_s[25:0];
      out_pc       = pc_mem[rd_ptr];
      // ANDI/ORI/XORI take an unsigned immediate regardless of build.
      logical_op_s = (head_instr_s[31:26] == 6'h0C) ||
                     (head_instr_s[31:26] == 6'h0D) ||
                     (head_instr_s[31:26] == 6'h0E);
      if (logical_op_s || (SIGN_EXT_IMM == 0)) begin
        imm_ext = {16'h0000, head_instr_s[15:0]};
      end else begin
        imm_ext = {{16{head_instr_s[15]}}, head_instr_s[15:0]};
      end
    end else begin
      logical_op_s = 1'b0;
    end
  end

  assign decode.instr = out_valid_s ? head_instr_s : 32'h0000_0000;
  assign decode.pc    = out_pc;

endmodule
